// File: rtl/mini_bus_pkg.sv
// rtl/mini_bus_pkg.sv - shared types and constants for the two-master bus fabric
package mini_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int M_INSTR = 0;
    localparam int M_DATA  = 1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mini_bus_decoder.sv
// rtl/mini_bus_decoder.sv - address to one-hot slave hit decoder with miss flag
module mini_bus_decoder #(
    parameter int                  N_SLV    = 4,
    parameter logic [N_SLV*32-1:0] SLV_BASE = {32'hF000_0000, 32'h0010_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLV*32-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFF0_0000, 32'hFFFF_C000, 32'hFFFF_C000}
) (
    input  logic [31:0]      addr,  // byte address to decode
    output logic [N_SLV-1:0] hit,   // one-hot selected slave
    output logic             miss   // no slave window matched
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if ((addr & SLV_MASK[k*32 +: 32]) == (SLV_BASE[k*32 +: 32] & SLV_MASK[k*32 +: 32])) begin
                hit    = '0;
                hit[k] = 1'b1;
            end
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/mini_bus_fabric.sv
// rtl/mini_bus_fabric.sv - two-master round-robin fabric to N_SLV slaves with timeout
module mini_bus_fabric
    import mini_bus_pkg::*;
#(
    parameter int                  N_SLV    = 4,
    parameter logic [N_SLV*32-1:0] SLV_BASE = {32'hF000_0000, 32'h0010_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLV*32-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFF0_0000, 32'hFFFF_C000, 32'hFFFF_C000},
    parameter int                  TIMEOUT  = 15,
    parameter logic [31:0]         ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,    // asynchronous, active low
    // masters: bit/word 0 = instruction, 1 = data
    input  logic [1:0]            m_valid,
    input  logic [63:0]           m_addr,
    input  logic [1:0]            m_wen,
    input  logic [63:0]           m_wdata,
    output logic [1:0]            m_good,
    output logic [1:0]            m_err,
    output logic [31:0]           m_rdata,
    // slaves
    output logic [N_SLV-1:0]      s_req,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_wdata,
    output logic                  s_wen,
    input  logic [N_SLV-1:0]      s_ack,
    input  logic [N_SLV*32-1:0]   s_rdata
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic              rr_ptr;      // preferred master when both request
    logic              grant;       // master owning the transaction in flight
    logic              grant_nxt;
    logic [N_SLV-1:0]  sel;
    logic [7:0]        wait_cnt;
    logic [31:0]       cand_addr;
    logic [31:0]       cand_wdata;
    logic              cand_wen;
    logic [N_SLV-1:0]  cand_hit;
    logic              cand_miss;
    logic [31:0]       sel_rdata;
    logic              ack_hit;
    logic [1:0]        grant_onehot;

    always_comb begin
        if (&m_valid) begin
            grant_nxt = rr_ptr;
        end else begin
            grant_nxt = m_valid[M_DATA];
        end
    end

    assign cand_addr  = grant_nxt ? m_addr[63:32]  : m_addr[31:0];
    assign cand_wdata = grant_nxt ? m_wdata[63:32] : m_wdata[31:0];
    assign cand_wen   = grant_nxt ? m_wen[1]       : m_wen[0];

    mini_bus_decoder #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decoder (
        .addr (cand_addr),
        .hit  (cand_hit),
        .miss (cand_miss)
    );

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (sel[k]) begin
                sel_rdata = sel_rdata | s_rdata[k*32 +: 32];
            end
        end
    end

    // Only the selected slave's ack matters; stray acks elsewhere are dropped.
    assign ack_hit = |(s_ack & sel);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|m_valid) begin
                    state_nxt = cand_miss ? ERR : REQ;
                end
            end
            REQ: begin
                if (ack_hit) begin
                    state_nxt = RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ERR;
                end
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= 1'(M_DATA);
            grant    <= 1'b0;
            sel      <= '0;
            wait_cnt <= '0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wen    <= 1'b0;
            m_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (|m_valid) begin
                        grant   <= grant_nxt;
                        sel     <= cand_hit;
                        s_addr  <= cand_addr;
                        s_wdata <= cand_wdata;
                        s_wen   <= cand_wen;
                        if (cand_miss) begin
                            m_rdata <= ERR_DATA;
                        end
                    end
                end
                REQ: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (ack_hit) begin
                        m_rdata <= s_wen ? 32'h0 : sel_rdata;
                    end else if (wait_cnt == WAIT_LAST) begin
                        m_rdata <= ERR_DATA;
                    end
                end
                RESP:    rr_ptr <= ~grant;
                ERR:     rr_ptr <= ~grant;
                default: ;
            endcase
        end
    end

    assign grant_onehot = {grant, ~grant};
    assign s_req        = (state == REQ)  ? sel          : '0;
    assign m_good       = (state == RESP) ? grant_onehot : 2'b00;
    assign m_err        = (state == ERR)  ? grant_onehot : 2'b00;

endmodule

// File: tb/tb_mini_bus_fabric.sv
// tb/tb_mini_bus_fabric.sv - directed self-checking bench for mini_bus_fabric
module tb_mini_bus_fabric;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_valid;
    logic [63:0] m_addr;
    logic [1:0]  m_wen;
    logic [63:0] m_wdata;
    logic [1:0]  m_good;
    logic [1:0]  m_err;
    logic [31:0] m_rdata;
    logic [3:0]  s_req;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_wen;
    logic [3:0]  s_ack;
    logic [127:0] s_rdata;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mini_bus_fabric dut (
        .clk     (clk),
        .reset   (reset),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wen   (m_wen),
        .m_wdata (m_wdata),
        .m_good  (m_good),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wen   (s_wen),
        .s_ack   (s_ack),
        .s_rdata (s_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid = '0;
        m_addr  = '0;
        m_wen   = '0;
        m_wdata = '0;
        s_ack   = '0;
        s_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({m_good, m_err, s_req, s_wen} !== 9'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 0", {m_good, m_err, s_req, s_wen});
        end
        checks++;
        if ({s_addr, s_wdata, m_rdata} !== 96'b0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", {s_addr, s_wdata, m_rdata});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({m_good, m_err, s_req} !== 8'b0) begin
            fails++;
            $display("FAIL post_reset_idle: got %b want 0", {m_good, m_err, s_req});
        end
    endtask

    task automatic test_data_read();
        idle_inputs();
        m_valid = 2'b10;
        m_addr  = {32'h0001_0004, 32'h0000_0000};
        tick();
        checks++;
        if (s_req !== 4'b0010) begin
            fails++;
            $display("FAIL rd_sreq: got %b want 0010", s_req);
        end
        checks++;
        if (s_addr !== 32'h0001_0004 || s_wen !== 1'b0) begin
            fails++;
            $display("FAIL rd_saddr: got %h/%b want 00010004/0", s_addr, s_wen);
        end
        s_ack   = 4'b0010;
        s_rdata = {32'h0, 32'h0, 32'h1234_5678, 32'h0};
        tick();
        checks++;
        if (m_good !== 2'b10 || m_err !== 2'b00 || s_req !== 4'b0000) begin
            fails++;
            $display("FAIL rd_good: got good=%b err=%b req=%b want 10/00/0000", m_good, m_err, s_req);
        end
        checks++;
        if (m_rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL rd_data: got %h want 12345678", m_rdata);
        end
        idle_inputs();
        tick();
        checks++;
        if (m_good !== 2'b00) begin
            fails++;
            $display("FAIL rd_one_pulse: got %b want 00", m_good);
        end
    endtask

    task automatic test_miss();
        idle_inputs();
        m_valid = 2'b10;
        m_wen   = 2'b10;
        m_addr  = {32'h8000_0000, 32'h0};
        m_wdata = {32'h0BAD_F00D, 32'h0};
        tick();
        checks++;
        if (s_req !== 4'b0000 || m_err !== 2'b10 || m_good !== 2'b00) begin
            fails++;
            $display("FAIL miss_err: got req=%b err=%b good=%b want 0000/10/00", s_req, m_err, m_good);
        end
        checks++;
        if (m_rdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL miss_data: got %h want deadbeef", m_rdata);
        end
        idle_inputs();
        tick();
        checks++;
        if (m_err !== 2'b00) begin
            fails++;
            $display("FAIL miss_one_pulse: got %b want 00", m_err);
        end
    endtask

    task automatic test_write();
        idle_inputs();
        m_valid = 2'b10;
        m_wen   = 2'b10;
        m_addr  = {32'h0010_0040, 32'h0};
        m_wdata = {32'hCAFE_0001, 32'h0};
        tick();
        checks++;
        if (s_req !== 4'b0100 || s_wen !== 1'b1 || s_wdata !== 32'hCAFE_0001) begin
            fails++;
            $display("FAIL wr_req: got req=%b wen=%b wdata=%h want 0100/1/cafe0001", s_req, s_wen, s_wdata);
        end
        s_ack   = 4'b0100;
        s_rdata = {32'h0, 32'h5555_5555, 32'h0, 32'h0};
        tick();
        checks++;
        if (m_good !== 2'b10 || m_rdata !== 32'h0) begin
            fails++;
            $display("FAIL wr_good: got good=%b rdata=%h want 10/00000000", m_good, m_rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int n;
        idle_inputs();
        m_valid = 2'b01;
        m_addr  = {32'h0, 32'h0000_0010};
        tick();
        n = 0;
        while (s_req === 4'b0001 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 15) begin
            fails++;
            $display("FAIL to_wait_cycles: got %0d want 15", n);
        end
        checks++;
        if (m_err !== 2'b01 || s_req !== 4'b0000 || m_good !== 2'b00) begin
            fails++;
            $display("FAIL to_err: got err=%b req=%b good=%b want 01/0000/00", m_err, s_req, m_good);
        end
        checks++;
        if (m_rdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL to_data: got %h want deadbeef", m_rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ignore_ack();
        idle_inputs();
        m_valid = 2'b01;
        m_addr  = {32'h0, 32'h0000_0020};
        tick();
        s_ack   = 4'b0100;
        s_rdata = {32'h0, 32'h2222_2222, 32'h0, 32'h0};
        tick();
        checks++;
        if (m_good !== 2'b00 || s_req !== 4'b0001) begin
            fails++;
            $display("FAIL stray_ack: got good=%b req=%b want 00/0001", m_good, s_req);
        end
        s_ack   = 4'b0001;
        s_rdata = {32'h0, 32'h2222_2222, 32'h0, 32'h0000_0A0A};
        tick();
        checks++;
        if (m_good !== 2'b01 || m_rdata !== 32'h0000_0A0A) begin
            fails++;
            $display("FAIL sel_ack: got good=%b rdata=%h want 01/00000a0a", m_good, m_rdata);
        end
        idle_inputs();
        s_ack = 4'b1111;
        tick();
        tick();
        checks++;
        if (m_good !== 2'b00 || m_err !== 2'b00 || s_req !== 4'b0000) begin
            fails++;
            $display("FAIL idle_ack: got good=%b err=%b req=%b want 0", m_good, m_err, s_req);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        int got;
        int cyc;
        exp_g[0] = 2'b10;
        exp_g[1] = 2'b01;
        exp_g[2] = 2'b10;
        exp_g[3] = 2'b01;
        idle_inputs();
        reset = 1'b0;
        tick();
        reset   = 1'b1;
        m_valid = 2'b11;
        m_addr  = {32'h0001_0200, 32'h0000_0100};
        s_rdata = {32'h0, 32'h0, 32'hB111_1111, 32'hA000_0000};
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 40) begin
            tick();
            cyc++;
            s_ack = s_req;
            if (m_good !== 2'b00) begin
                checks++;
                if (m_good !== exp_g[got]) begin
                    fails++;
                    $display("FAIL rr_grant%0d: got %b want %b", got, m_good, exp_g[got]);
                end
                checks++;
                if (m_rdata !== ((exp_g[got] == 2'b10) ? 32'hB111_1111 : 32'hA000_0000)) begin
                    fails++;
                    $display("FAIL rr_data%0d: got %h", got, m_rdata);
                end
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            fails++;
            $display("FAIL rr_count: got %0d want 4", got);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int bad;
        idle_inputs();
        m_valid = 2'b10;
        m_addr  = {32'h0001_0004, 32'h0};
        tick();
        checks++;
        if (s_req !== 4'b0010) begin
            fails++;
            $display("FAIL mid_sreq: got %b want 0010", s_req);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({s_req, m_good, m_err, s_wen} !== 9'b0 || s_addr !== 32'h0 || m_rdata !== 32'h0) begin
            fails++;
            $display("FAIL mid_async: got req=%b good=%b err=%b addr=%h want 0", s_req, m_good, m_err, s_addr);
        end
        tick();
        m_valid = 2'b00;
        s_ack   = 4'b0010;
        s_rdata = {32'h0, 32'h0, 32'h7777_7777, 32'h0};
        reset   = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_good !== 2'b00 || m_err !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_no_pulse: got %0d pulse cycles want 0", bad);
        end
        s_ack   = 4'b0000;
        m_valid = 2'b11;
        m_addr  = {32'h0001_0008, 32'h0000_0020};
        tick();
        checks++;
        if (s_req !== 4'b0010) begin
            fails++;
            $display("FAIL mid_fresh_grant: got %b want 0010", s_req);
        end
        s_ack = 4'b0010;
        tick();
        checks++;
        if (m_good !== 2'b10 || m_rdata !== 32'h7777_7777) begin
            fails++;
            $display("FAIL mid_fresh_good: got good=%b rdata=%h want 10/77777777", m_good, m_rdata);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_data_read();
        test_miss();
        test_write();
        test_timeout();
        test_ignore_ack();
        test_round_robin();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
